osd_mam_wb_arb: RTL and testbench

// - Two-master Wishbone B3 arbiter sharing one memory slave between the system

---
 rtl/osd_mam_wb_arb.sv | 199 +++++++++++++++++++
 tb/tb_osd_mam_wb_arb.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_mam_wb_arb.sv
// Two-master Wishbone B3 arbiter: CPU data port (m0) and debug MAM (m1)
// share one memory slave. Round-robin, cycle-granular grants, with a stall
// watchdog that aborts a hung slave access so debug access is never locked out.
module osd_mam_wb_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024,
  localparam int SW        = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  input  logic [SW-1:0]         m0_sel_i,
  input  logic [2:0]            m0_cti_i,
  input  logic [1:0]            m0_bte_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  input  logic [SW-1:0]         m1_sel_i,
  input  logic [2:0]            m1_cti_i,
  input  logic [1:0]            m1_bte_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,

  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic [SW-1:0]         s_sel_o,
  output logic [2:0]            s_cti_o,
  output logic [1:0]            s_bte_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,

  output logic [1:0]            grant_o
);

  // Watchdog counter width; kept at least one bit so TIMEOUT=0 still elaborates.
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WD_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;     // index of the master released most recently
  logic [WW-1:0]   wdog_q, wdog_d;
  logic            abort_q, abort_d;
  logic            err_q, err_d;

  logic            own_id;
  logic            own_cyc;
  logic            own_stb;
  logic            oth_cyc;

  // Arbitration, release hand-over and stall watchdog next-state.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    abort_d = abort_q;
    err_d   = 1'b0;
    own_id  = 1'b0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    oth_cyc = 1'b0;

    unique case (state_q)
      IDLE: begin
        wdog_d  = '0;
        abort_d = 1'b0;
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end

      GNT0, GNT1: begin
        own_id  = (state_q == GNT1);
        own_cyc = own_id ? m1_cyc_i : m0_cyc_i;
        own_stb = own_id ? m1_stb_i : m0_stb_i;
        oth_cyc = own_id ? m0_cyc_i : m1_cyc_i;

        if (!own_cyc) begin
          // Release goes straight to a waiting master, no IDLE bubble.
          last_d  = own_id;
          wdog_d  = '0;
          abort_d = 1'b0;
          if (oth_cyc) begin
            state_d = own_id ? GNT0 : GNT1;
          end else begin
            state_d = IDLE;
          end
        end else if ((TIMEOUT != 0) && !abort_q) begin
          if (s_ack_i) begin
            wdog_d = '0;
          end else if (own_stb) begin
            if (wdog_q == WD_LAST) begin
              abort_d = 1'b1;
              err_d   = 1'b1;
            end else if (wdog_q != '1) begin
              wdog_d = wdog_q + WW'(1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and watchdog registers; reset drops the slave cycle immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  // Bus mux driven purely by the owner state; aborted cycles keep cyc/stb low.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;

    unique case (state_q)
      GNT0: begin
        s_cyc_o  = m0_cyc_i & ~abort_q;
        s_stb_o  = m0_stb_i & ~abort_q;
        s_we_o   = m0_we_i;
        s_addr_o = m0_addr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i & ~abort_q;
        m0_err_o = err_q;
        grant_o  = 2'b01;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i & ~abort_q;
        s_stb_o  = m1_stb_i & ~abort_q;
        s_we_o   = m1_we_i;
        s_addr_o = m1_addr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i & ~abort_q;
        m1_err_o = err_q;
        grant_o  = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_osd_mam_wb_arb.sv
// Bench for osd_mam_wb_arb: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the arbiter rules.
module tb_osd_mam_wb_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst;

  logic           mc   [2];
  logic           ms   [2];
  logic           mw   [2];
  logic [AW-1:0]  ma   [2];
  logic [DW-1:0]  md   [2];
  logic [SW-1:0]  msel [2];
  logic [2:0]     mcti [2];
  logic [1:0]     mbte [2];

  logic [DW-1:0]  m0_dat_o, m1_dat_o;
  logic           m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic           s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]  s_addr_o;
  logic [DW-1:0]  s_dat_o;
  logic [SW-1:0]  s_sel_o;
  logic [2:0]     s_cti_o;
  logic [1:0]     s_bte_o;
  logic [DW-1:0]  s_dat_i;
  logic           s_ack_i;
  logic [1:0]     grant_o;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  osd_mam_wb_arb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .m0_cyc_i  (mc[0]),
    .m0_stb_i  (ms[0]),
    .m0_we_i   (mw[0]),
    .m0_addr_i (ma[0]),
    .m0_dat_i  (md[0]),
    .m0_sel_i  (msel[0]),
    .m0_cti_i  (mcti[0]),
    .m0_bte_i  (mbte[0]),
    .m0_dat_o  (m0_dat_o),
    .m0_ack_o  (m0_ack_o),
    .m0_err_o  (m0_err_o),
    .m1_cyc_i  (mc[1]),
    .m1_stb_i  (ms[1]),
    .m1_we_i   (mw[1]),
    .m1_addr_i (ma[1]),
    .m1_dat_i  (md[1]),
    .m1_sel_i  (msel[1]),
    .m1_cti_i  (mcti[1]),
    .m1_bte_i  (mbte[1]),
    .m1_dat_o  (m1_dat_o),
    .m1_ack_o  (m1_ack_o),
    .m1_err_o  (m1_err_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_addr_o  (s_addr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_cti_o   (s_cti_o),
    .s_bte_o   (s_bte_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .grant_o   (grant_o)
  );

  function automatic logic [145:0] outs();
    return {s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o,
            m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o, grant_o};
  endfunction

  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      mc[m] = 1'b0; ms[m] = 1'b0; mw[m] = 1'b0; ma[m] = '0;
      md[m] = '0; msel[m] = '0; mcti[m] = '0; mbte[m] = '0;
    end
    s_ack_i = 1'b0;
    s_dat_i = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 32'h1234; s_ack_i = 1'b1; s_dat_i = 32'hFFFF_FFFF;
    next_cycle();
    @(negedge clk);
    nvec++;
    if (outs() !== '0) begin
      nerr++; $display("FAIL reset_outputs: got %h expected 0", outs());
    end
    clear_inputs();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if ({s_cyc_o, grant_o} !== 3'b000) begin
      nerr++; $display("FAIL reset_idle: got cyc/grant %b expected 000", {s_cyc_o, grant_o});
    end
  endtask

  task automatic test_single_write();
    next_cycle();
    mc[0] = 1'b1; ms[0] = 1'b1; mw[0] = 1'b1; ma[0] = 32'h100;
    md[0] = 32'hDEADBEEF; msel[0] = 4'hF;
    @(negedge clk);
    nvec++;
    if ({s_cyc_o, grant_o} !== 3'b000) begin
      nerr++; $display("FAIL write_arb_latency: got cyc/grant %b expected 000", {s_cyc_o, grant_o});
    end
    next_cycle();
    @(negedge clk);
    nvec++;
    if ({s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, grant_o, m0_ack_o} !==
        {3'b111, 32'h100, 32'hDEADBEEF, 4'hF, 2'b01, 1'b0}) begin
      nerr++;
      $display("FAIL write_bus: got %b %h %h %h %b %b expected 111 100 deadbeef f 01 0",
               {s_cyc_o, s_stb_o, s_we_o}, s_addr_o, s_dat_o, s_sel_o, grant_o, m0_ack_o);
    end
    next_cycle();
    s_ack_i = 1'b1;
    @(negedge clk);
    nvec++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
      nerr++; $display("FAIL write_ack: got m0/m1 ack %b expected 10", {m0_ack_o, m1_ack_o});
    end
    next_cycle();
    s_ack_i = 1'b0; mc[0] = 1'b0; ms[0] = 1'b0;
    @(negedge clk);
    nvec++;
    if ({m0_ack_o, grant_o} !== 3'b001) begin
      nerr++; $display("FAIL write_ack_pulse: got ack/grant %b expected 001", {m0_ack_o, grant_o});
    end
    next_cycle();
    @(negedge clk);
    nvec++;
    if ({s_cyc_o, grant_o} !== 3'b000) begin
      nerr++; $display("FAIL write_to_idle: got cyc/grant %b expected 000", {s_cyc_o, grant_o});
    end
  endtask

  task automatic test_tie();
    rst = 1'b1;
    clear_inputs();
    mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 32'h200;
    mc[1] = 1'b1; ms[1] = 1'b1; ma[1] = 32'h300;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    nvec++;
    if ({grant_o, s_addr_o} !== {2'b01, 32'h200}) begin
      nerr++; $display("FAIL tie_m0_first: got grant %b addr %h expected 01 200", grant_o, s_addr_o);
    end
    next_cycle();
    s_ack_i = 1'b1; s_dat_i = 32'h1111_2222;
    @(negedge clk);
    nvec++;
    if ({m0_ack_o, m0_dat_o, m1_ack_o, m1_dat_o} !== {1'b1, 32'h1111_2222, 1'b0, 32'h0}) begin
      nerr++;
      $display("FAIL tie_read_m0: got %b %h %b %h expected 1 11112222 0 0",
               m0_ack_o, m0_dat_o, m1_ack_o, m1_dat_o);
    end
    next_cycle();
    s_ack_i = 1'b0; mc[0] = 1'b0; ms[0] = 1'b0;
    @(negedge clk);
    nvec++;
    if (grant_o !== 2'b01) begin
      nerr++; $display("FAIL tie_release_cycle: got grant %b expected 01", grant_o);
    end
    next_cycle();
    @(negedge clk);
    nvec++;
    if ({grant_o, s_cyc_o, s_addr_o} !== {2'b10, 1'b1, 32'h300}) begin
      nerr++;
      $display("FAIL tie_no_idle_gap: got grant %b cyc %b addr %h expected 10 1 300",
               grant_o, s_cyc_o, s_addr_o);
    end
    next_cycle();
    s_ack_i = 1'b1; s_dat_i = 32'h3333_4444;
    @(negedge clk);
    nvec++;
    if ({m1_ack_o, m1_dat_o, m0_ack_o, m0_dat_o} !== {1'b1, 32'h3333_4444, 1'b0, 32'h0}) begin
      nerr++;
      $display("FAIL tie_read_m1: got %b %h %b %h expected 1 33334444 0 0",
               m1_ack_o, m1_dat_o, m0_ack_o, m0_dat_o);
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_burst();
    logic [2:0] cti;
    next_cycle();
    mc[1] = 1'b1; ms[1] = 1'b1; mw[1] = 1'b1; ma[1] = 32'h400; md[1] = $urandom;
    mcti[1] = 3'b010; mbte[1] = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      cti = (i == 3) ? 3'b111 : 3'b010;
      ma[1] = 32'h400 + 32'(4 * i); mcti[1] = cti; md[1] = $urandom;
      s_ack_i = 1'b1;
      mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 32'h500;
      @(negedge clk);
      nvec++;
      if ({grant_o, s_addr_o, s_cti_o} !== {2'b10, 32'h400 + 32'(4 * i), cti}) begin
        nerr++;
        $display("FAIL burst_beat%0d: got grant %b addr %h cti %b expected 10 %h %b",
                 i, grant_o, s_addr_o, s_cti_o, 32'h400 + 32'(4 * i), cti);
      end
      nvec++;
      if ({m1_ack_o, m0_ack_o} !== 2'b10) begin
        nerr++; $display("FAIL burst_ack%0d: got m1/m0 ack %b expected 10", i, {m1_ack_o, m0_ack_o});
      end
    end
    next_cycle();
    mc[1] = 1'b0; ms[1] = 1'b0; s_ack_i = 1'b0;
    @(negedge clk);
    nvec++;
    if (grant_o !== 2'b10) begin
      nerr++; $display("FAIL burst_release_cycle: got grant %b expected 10", grant_o);
    end
    next_cycle();
    @(negedge clk);
    nvec++;
    if ({grant_o, s_addr_o} !== {2'b01, 32'h500}) begin
      nerr++; $display("FAIL burst_handover: got grant %b addr %h expected 01 500", grant_o, s_addr_o);
    end
    next_cycle();
    s_ack_i = 1'b1;
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_timeout();
    next_cycle();
    mc[1] = 1'b1; ms[1] = 1'b1; mw[1] = 1'b0; ma[1] = 32'h600;
    @(negedge clk);
    for (int k = 0; k <= 10; k++) begin
      next_cycle();
      s_ack_i = (k == 9);
      @(negedge clk);
      nvec++;
      if ({m1_err_o, m0_err_o, s_stb_o, s_cyc_o, m1_ack_o} !==
          {(k == 8), 1'b0, (k < 8), (k < 8), 1'b0}) begin
        nerr++;
        $display("FAIL timeout_k%0d: got err1/err0/stb/cyc/ack %b expected %b", k,
                 {m1_err_o, m0_err_o, s_stb_o, s_cyc_o, m1_ack_o},
                 {(k == 8), 1'b0, (k < 8), (k < 8), 1'b0});
      end
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    nvec++;
    if ({grant_o, m1_err_o} !== 3'b100) begin
      nerr++; $display("FAIL timeout_release: got grant/err %b expected 100", {grant_o, m1_err_o});
    end
    next_cycle();
    @(negedge clk);
    nvec++;
    if (grant_o !== 2'b00) begin
      nerr++; $display("FAIL timeout_idle: got grant %b expected 00", grant_o);
    end
  endtask

  task automatic test_alternate();
    int exp_owner;
    int cnt;
    next_cycle();
    mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 32'hA00;
    mc[1] = 1'b1; ms[1] = 1'b1; ma[1] = 32'hB00;
    @(negedge clk);
    exp_owner = 0;
    cnt = 0;
    repeat (44) begin
      next_cycle();
      mc[exp_owner] = (cnt < 10); ms[exp_owner] = (cnt < 10);
      mc[1 - exp_owner] = 1'b1;   ms[1 - exp_owner] = 1'b1;
      s_ack_i = (cnt < 10) && ((cnt % 3 == 2) || ($urandom % 2 == 0));
      @(negedge clk);
      nvec++;
      if (grant_o !== ((exp_owner == 0) ? 2'b01 : 2'b10)) begin
        nerr++; $display("FAIL alt_grant: got %b expected owner m%0d", grant_o, exp_owner);
      end
      nvec++;
      if (((exp_owner == 0) ? {m1_ack_o, m1_err_o} : {m0_ack_o, m0_err_o}) !== 2'b00) begin
        nerr++;
        $display("FAIL alt_nonowner: got m0 %b m1 %b with owner m%0d, expected non-owner 00",
                 {m0_ack_o, m0_err_o}, {m1_ack_o, m1_err_o}, exp_owner);
      end
      if (cnt == 10) begin
        exp_owner = 1 - exp_owner;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
    next_cycle();
    clear_inputs();
    repeat (3) next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    next_cycle();
    mc[1] = 1'b1; ms[1] = 1'b1; mw[1] = 1'b1; ma[1] = 32'h700; mcti[1] = 3'b010;
    @(negedge clk);
    next_cycle();
    s_ack_i = 1'b1;
    mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 32'h800;
    @(negedge clk);
    nvec++;
    if (grant_o !== 2'b10) begin
      nerr++; $display("FAIL midrst_owner: got grant %b expected 10", grant_o);
    end
    next_cycle();
    ma[1] = 32'h704;
    #2;
    rst = 1'b1;
    #1;
    nvec++;
    if (outs() !== '0) begin
      nerr++; $display("FAIL midrst_async: got %h expected 0", outs());
    end
    @(negedge clk);
    next_cycle();
    rst = 1'b0; s_ack_i = 1'b0;
    @(negedge clk);
    nvec++;
    if (grant_o !== 2'b00) begin
      nerr++; $display("FAIL midrst_idle: got grant %b expected 00", grant_o);
    end
    next_cycle();
    @(negedge clk);
    nvec++;
    if ({grant_o, s_addr_o} !== {2'b01, 32'h800}) begin
      nerr++; $display("FAIL midrst_favours_m0: got grant %b addr %h expected 01 800", grant_o, s_addr_o);
    end
    next_cycle();
    clear_inputs();
    repeat (2) next_cycle();
  endtask

  task automatic test_random();
    int          owner;      // -1: nobody holds the slave
    int          last_rel;   // master released most recently
    int          stall;      // consecutive stalled strobe cycles of the owner
    bit          aborted, errp, errn, done;
    bit          act [2];
    int          beats [2];
    int          total [2];
    bit          prev_ack [2];
    bit          prev_err [2];
    int          hung;
    logic        e_scyc, e_sstb, e_swe;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_sdat;
    logic [SW-1:0] e_sel;
    logic [2:0]  e_cti;
    logic [1:0]  e_bte, e_gnt;
    logic        e_ack [2];
    logic        e_err [2];
    logic [DW-1:0] e_dat [2];
    logic [145:0] exp_v;

    rst = 1'b1;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
    owner = -1; last_rel = 1; stall = 0; aborted = 1'b0; errp = 1'b0; hung = 0;
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0; beats[m] = 0; total[m] = 0; prev_ack[m] = 1'b0; prev_err[m] = 1'b0;
    end

    repeat (400) begin
      next_cycle();
      for (int m = 0; m < 2; m++) begin
        done = 1'b0;
        if (act[m]) begin
          if (prev_err[m]) begin
            act[m] = 1'b0; done = 1'b1;
          end else if (prev_ack[m]) begin
            beats[m]--; ma[m] = ma[m] + 32'd4; md[m] = $urandom;
            if (beats[m] == 0) begin
              act[m] = 1'b0; done = 1'b1;
            end
          end
        end
        if (!act[m] && !done && ($urandom % 4 == 0)) begin
          act[m] = 1'b1;
          total[m] = $urandom_range(1, 4);
          beats[m] = total[m];
          ma[m] = $urandom & 32'hFFFF_FFFC;
          md[m] = $urandom;
          msel[m] = 4'($urandom);
          mw[m] = 1'($urandom);
          mbte[m] = 2'($urandom);
        end
        mc[m] = act[m];
        ms[m] = act[m] && ($urandom % 5 != 0);
        mcti[m] = (!act[m] || total[m] == 1) ? 3'b000 : ((beats[m] == 1) ? 3'b111 : 3'b010);
      end
      if (hung > 0) hung--;
      else if ($urandom % 50 == 0) hung = 12;
      s_dat_i = $urandom;
      s_ack_i = 1'b0;
      if (owner >= 0) begin
        s_ack_i = !aborted && ms[owner] && (hung == 0) && ($urandom % 3 != 0);
      end

      @(negedge clk);
      e_scyc = 1'b0; e_sstb = 1'b0; e_swe = 1'b0; e_addr = '0; e_sdat = '0;
      e_sel = '0; e_cti = '0; e_bte = '0; e_gnt = 2'b00;
      for (int m = 0; m < 2; m++) begin
        e_ack[m] = 1'b0; e_err[m] = 1'b0; e_dat[m] = '0;
      end
      if (owner >= 0) begin
        e_scyc = mc[owner] & ~aborted;
        e_sstb = ms[owner] & ~aborted;
        e_swe  = mw[owner];
        e_addr = ma[owner];
        e_sdat = md[owner];
        e_sel  = msel[owner];
        e_cti  = mcti[owner];
        e_bte  = mbte[owner];
        e_ack[owner] = s_ack_i & ~aborted;
        e_err[owner] = errp;
        e_dat[owner] = s_dat_i;
        e_gnt = (owner == 0) ? 2'b01 : 2'b10;
      end
      exp_v = {e_scyc, e_sstb, e_swe, e_addr, e_sdat, e_sel, e_cti, e_bte,
               e_ack[0], e_err[0], e_dat[0], e_ack[1], e_err[1], e_dat[1], e_gnt};
      nvec++;
      if (outs() !== exp_v) begin
        nerr++; $display("FAIL random_cycle: got %h expected %h", outs(), exp_v);
      end

      // Advance the reference: grant rules, release hand-over, stall abort.
      errn = 1'b0;
      if (owner < 0) begin
        if (mc[0] && mc[1]) owner = 1 - last_rel;
        else if (mc[0])     owner = 0;
        else if (mc[1])     owner = 1;
        stall = 0; aborted = 1'b0;
      end else if (!mc[owner]) begin
        last_rel = owner;
        owner = mc[1 - owner] ? (1 - owner) : -1;
        stall = 0; aborted = 1'b0;
      end else if (!aborted) begin
        if (s_ack_i) begin
          stall = 0;
        end else if (ms[owner]) begin
          stall++;
          if (stall >= TO) begin
            aborted = 1'b1; errn = 1'b1;
          end
        end
      end
      errp = errn;
      for (int m = 0; m < 2; m++) begin
        prev_ack[m] = e_ack[m];
        prev_err[m] = e_err[m];
      end
    end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_write();
    test_tie();
    test_burst();
    test_timeout();
    test_alternate();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
